led_fader: RTL and testbench

Per-LED brightness fader placed directly downstream of the one-second LED rotator. It takes the rotator's 8-bit on/off pattern and converts each bit into an 8-bit brightness level that ramps up when the bit sets and decays when it clears. Each level drives one PWM output, so a rotating pattern shows as a moving light with a fading trail. The outputs drive the board LED pins directly.

---
 rtl/led_fader.sv | 93 +++++++++
 tb/tb_led_fader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// Per-LED brightness fader: turns each on/off pattern bit into an 8-bit level that
// ramps toward its target once per fade tick, then drives one PWM output per channel.
module led_fader #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int FADE_HZ   = 1_000,
    parameter int RISE_STEP = 64,
    parameter int FALL_STEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pattern_in,
    input  logic [7:0] max_level,
    output logic [7:0] led_out,
    output logic       busy
);

    localparam int              DIV      = CLK_FREQ / FADE_HZ;
    localparam int              DIV_W    = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [8:0]      RISE9    = 9'(RISE_STEP);
    localparam logic [8:0]      FALL9    = 9'(FALL_STEP);

    logic [7:0]       pat_q;
    logic [7:0]       pat_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [7:0]       pwm_cnt_q;
    logic [7:0]       pwm_cnt_d;
    logic [7:0]       led_q;
    logic [7:0]       led_d;
    logic [7:0]       level_q [8];
    logic [7:0]       level_d [8];
    logic [7:0]       target  [8];
    logic [7:0]       mismatch;
    logic             tick;
    logic [8:0]       rise_sum;
    logic [8:0]       fall_dif;

    assign tick      = (div_q == DIV_LAST);
    assign div_d     = tick ? '0 : div_q + DIV_W'(1);
    assign pwm_cnt_d = pwm_cnt_q + 8'd1;
    assign pat_d     = pattern_in;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            target[i]   = pat_q[i] ? max_level : 8'd0;
            mismatch[i] = (level_q[i] != target[i]);
            led_d[i]    = (level_q[i] > pwm_cnt_q);
        end
    end

    // The 9-bit sum/difference exposes overflow and borrow, so a step never wraps past the target.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
        rise_sum = '0;
        fall_dif = '0;
        for (int i = 0; i < 8; i++) begin
            level_d[i] = level_q[i];
            rise_sum   = {1'b0, level_q[i]} + RISE9;
            fall_dif   = {1'b0, level_q[i]} - FALL9;
            if (tick) begin
                if (level_q[i] < target[i]) begin
                    level_d[i] = (rise_sum > {1'b0, target[i]}) ? target[i] : rise_sum[7:0];
                end else if (level_q[i] > target[i]) begin
                    level_d[i] = (fall_dif[8] || (fall_dif[7:0] < target[i])) ? target[i]
                                                                                : fall_dif[7:0];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q     <= '0;
            div_q     <= '0;
            pwm_cnt_q <= '0;
            led_q     <= '0;
            // NOTE: the level array is real channel state (not storage), so it is cleared on reset.
            for (int i = 0; i < 8; i++) level_q[i] <= '0;
        end else begin
            pat_q     <= pat_d;
            div_q     <= div_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            for (int i = 0; i < 8; i++) level_q[i] <= level_d[i];
        end
    end

    assign led_out = led_q;
    assign busy    = |mismatch;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: directed fade/PWM scenarios plus a randomized
// run compared every cycle against an integer-arithmetic reference model.
module tb_led_fader;

    localparam int CLK_FREQ  = 1000;
    localparam int FADE_HZ   = 100;
    localparam int DIV       = CLK_FREQ / FADE_HZ;
    localparam int RISE_STEP = 64;
    localparam int FALL_STEP = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] pattern_in;
    logic [7:0] max_level;
    logic [7:0] led_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    led_fader #(
        .CLK_FREQ (CLK_FREQ),
        .FADE_HZ  (FADE_HZ),
        .RISE_STEP(RISE_STEP),
        .FALL_STEP(FALL_STEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pattern_in(pattern_in),
        .max_level (max_level),
        .led_out   (led_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers, fade ticks counted since reset, min/max stepping.
    int         m_lvl [8];
    logic [7:0] m_pat;
    int         m_cycles;
    int         m_pwm;
    logic [7:0] m_led;
    int         m_tgt;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_lvl[i] = 0;
            m_pat = 8'h00; m_cycles = 0; m_pwm = 0; m_led = 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) m_led[i] = (m_lvl[i] > m_pwm);
            if ((m_cycles % DIV) == DIV - 1) begin
                for (int i = 0; i < 8; i++) begin
                    m_tgt = m_pat[i] ? int'(max_level) : 0;
                    if (m_lvl[i] < m_tgt)
                        m_lvl[i] = (m_lvl[i] + RISE_STEP < m_tgt) ? m_lvl[i] + RISE_STEP : m_tgt;
                    else if (m_lvl[i] > m_tgt)
                        m_lvl[i] = (m_lvl[i] - FALL_STEP > m_tgt) ? m_lvl[i] - FALL_STEP : m_tgt;
                end
            end
            m_cycles = m_cycles + 1;
            m_pwm    = (m_pwm + 1) % 256;
            m_pat    = pattern_in;
        end
    end

    function automatic bit m_busy();
        for (int i = 0; i < 8; i++)
            if (m_lvl[i] != (m_pat[i] ? int'(max_level) : 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lvl(input int i);
        return int'(dut.level_q[i]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        pattern_in = 8'hFF; max_level = 8'd255; rst_n = 1'b0;
        cyc(3);
        total++; if (led_out !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", led_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (dut.div_q !== '0) begin bad++; $display("FAIL reset_div got=%0d exp=0", dut.div_q); end
        for (int i = 0; i < 8; i++) begin
            total++; if (lvl(i) !== 0) begin bad++; $display("FAIL reset_level%0d got=%0d exp=0", i, lvl(i)); end
        end
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (first < 0 && lvl(0) != 0) first = k;
        end
        total++; if (first !== DIV) begin bad++; $display("FAIL reset_first_tick got=%0d exp=%0d", first, DIV); end
    endtask

    task automatic test_rise();
        int q[$];
        int prev;
        logic prev_busy;
        logic busy_at_last;
        int highs;
        logic [7:0] others;
        pattern_in = 8'h00; max_level = 8'd255;
        do_reset();
        pattern_in = 8'h01;
        busy_at_last = 1'bx; prev_busy = 1'bx;
        for (int k = 0; k < 80 && q.size() < 4; k++) begin
            prev = lvl(0); prev_busy = busy;
            cyc(1);
            if (lvl(0) != prev) q.push_back(lvl(0));
            if (q.size() == 4) busy_at_last = busy;
        end
        total++; if (q.size() !== 4) begin bad++; $display("FAIL rise_steps got=%0d exp=4", q.size()); end
        for (int k = 0; k < q.size() && k < 4; k++) begin
            total++;
            if (q[k] !== ((k == 3) ? 255 : 64 * (k + 1))) begin
                bad++; $display("FAIL rise_level[%0d] got=%0d exp=%0d", k, q[k], (k == 3) ? 255 : 64 * (k + 1));
            end
        end
        total++; if (prev_busy !== 1'b1) begin bad++; $display("FAIL rise_busy_before got=%b exp=1", prev_busy); end
        total++; if (busy_at_last !== 1'b0) begin bad++; $display("FAIL rise_busy_after got=%b exp=0", busy_at_last); end
        cyc(2);
        highs = 0; others = 8'h00;
        for (int k = 0; k < 256; k++) begin
            cyc(1);
            highs += int'(led_out[0]);
            others |= led_out & 8'hFE;
        end
        total++; if (highs !== 255) begin bad++; $display("FAIL rise_duty got=%0d exp=255", highs); end
        total++; if (others !== 8'h00) begin bad++; $display("FAIL rise_other_leds got=%h exp=00", others); end
    endtask

    task automatic test_decay();
        int n;
        int prev;
        logic any_led;
        logic any_busy;
        pattern_in = 8'h00;
        n = 0;
        for (int k = 0; k < 400 && lvl(0) != 0; k++) begin
            prev = lvl(0);
            cyc(1);
            if (lvl(0) != prev) begin
                n++;
                total++;
                if (lvl(0) !== ((255 - 8 * n > 0) ? 255 - 8 * n : 0)) begin
                    bad++; $display("FAIL decay_level[%0d] got=%0d exp=%0d", n, lvl(0), (255 - 8 * n > 0) ? 255 - 8 * n : 0);
                end
            end
        end
        total++; if (n !== 32) begin bad++; $display("FAIL decay_ticks got=%0d exp=32", n); end
        cyc(2);
        any_led = 1'b0; any_busy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            any_led |= led_out[0];
            any_busy |= busy;
        end
        total++; if (any_led !== 1'b0) begin bad++; $display("FAIL decay_led got=%b exp=0", any_led); end
        total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL decay_busy got=%b exp=0", any_busy); end
    endtask

    task automatic test_pwm_duty();
        int n;
        int prev;
        int highs [8];
        bit settled;
        pattern_in = 8'hFF; max_level = 8'd128;
        n = 0; settled = 1'b0;
        for (int k = 0; k < 60 && !settled; k++) begin
            prev = lvl(0);
            cyc(1);
            if (lvl(0) != prev) n++;
            settled = !busy;
            for (int i = 0; i < 8; i++) if (lvl(i) != 128) settled = 1'b0;
        end
        total++; if (!settled) begin bad++; $display("FAIL pwm_settle got=unsettled exp=all_128"); end
        total++; if (n !== 2) begin bad++; $display("FAIL pwm_ticks got=%0d exp=2", n); end
        cyc(1);
        for (int i = 0; i < 8; i++) highs[i] = 0;
        for (int k = 0; k < 256; k++) begin
            cyc(1);
            for (int i = 0; i < 8; i++) highs[i] += int'(led_out[i]);
        end
        for (int i = 0; i < 8; i++) begin
            total++; if (highs[i] !== 128) begin bad++; $display("FAIL pwm_duty%0d got=%0d exp=128", i, highs[i]); end
        end
    endtask

    task automatic test_max_drop();
        int n;
        int prev;
        int busy_bad;
        int hold_bad;
        pattern_in = 8'h00; max_level = 8'd255;
        do_reset();
        pattern_in = 8'h01;
        for (int k = 0; k < 80 && !(lvl(0) == 255 && !busy); k++) cyc(1);
        total++; if (lvl(0) !== 255) begin bad++; $display("FAIL drop_start got=%0d exp=255", lvl(0)); end
        max_level = 8'd100;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy_rise got=%b exp=1", busy); end
        n = 0; busy_bad = 0;
        for (int k = 0; k < 300 && lvl(0) != 100; k++) begin
            prev = lvl(0);
            cyc(1);
            if (lvl(0) != prev) begin
                n++;
                total++;
                if (lvl(0) !== ((n < 20) ? 255 - 8 * n : 100)) begin
                    bad++; $display("FAIL drop_level[%0d] got=%0d exp=%0d", n, lvl(0), (n < 20) ? 255 - 8 * n : 100);
                end
            end
            if (lvl(0) != 100 && busy !== 1'b1) busy_bad++;
        end
        total++; if (n !== 20) begin bad++; $display("FAIL drop_ticks got=%0d exp=20", n); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL drop_busy_during got=%0d_low exp=0_low", busy_bad); end
        hold_bad = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (lvl(0) != 100 || busy !== 1'b0) hold_bad++;
        end
        total++; if (hold_bad !== 0) begin bad++; $display("FAIL drop_hold got=%0d_bad_cycles exp=0", hold_bad); end
    endtask

    task automatic test_reset_mid_fade();
        pattern_in = 8'h00; max_level = 8'd255;
        do_reset();
        pattern_in = 8'h01;
        for (int k = 0; k < 60 && lvl(0) != 128; k++) cyc(1);
        cyc(3);
        total++; if (lvl(0) !== 128 || busy !== 1'b1) begin
            bad++; $display("FAIL midfade_pre got=%0d/%b exp=128/1", lvl(0), busy);
        end
        rst_n = 1'b0;
        cyc(1);
        total++; if (lvl(0) !== 0) begin bad++; $display("FAIL midfade_level got=%0d exp=0", lvl(0)); end
        total++; if (led_out !== 8'h00) begin bad++; $display("FAIL midfade_led got=%h exp=00", led_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midfade_busy got=%b exp=0", busy); end
        total++; if (dut.pwm_cnt_q !== 8'd0) begin bad++; $display("FAIL midfade_pwm got=%0d exp=0", dut.pwm_cnt_q); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int bad_idx;
        pattern_in = 8'h00; max_level = 8'd200;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            cyc(1);
            total++; if (led_out !== m_led) begin bad++; $display("FAIL rand_led cyc=%0d got=%h exp=%h", k, led_out, m_led); end
            total++; if (busy !== m_busy()) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", k, busy, m_busy()); end
            bad_idx = -1;
            for (int i = 0; i < 8; i++) if (bad_idx < 0 && lvl(i) != m_lvl[i]) bad_idx = i;
            total++; if (bad_idx >= 0) begin
                bad++; $display("FAIL rand_level%0d cyc=%0d got=%0d exp=%0d", bad_idx, k, lvl(bad_idx), m_lvl[bad_idx]);
            end
            rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 39) == 0) pattern_in = 8'($urandom);
            else if ($urandom_range(0, 59) == 0) pattern_in = pattern_in ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 599) == 0) max_level = 8'($urandom);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pattern_in = 8'h00; max_level = 8'h00;
        @(negedge clk);
        test_reset();
        test_rise();
        test_decay();
        test_pwm_duty();
        test_max_drop();
        test_reset_mid_fade();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
